// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU internal data bus: arbiter state encoding
// and the default bus width.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam int BUS_WIDTH = 8;

endpackage

// File: rtl/eight_bit_mux.sv
// 2:1 byte mux feeding the internal data bus; control=0 passes in1, control=1 passes in2.
module eight_bit_mux #(
  parameter int WIDTH = 8
) (
  input  logic             control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out
);

  assign out = control ? in2 : in1;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal data bus with a per-grant beat quota and a
// registered valid/ready output stage towards the downstream write port.
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            last_served, last_served_next;
  logic            sel_next;
  logic            space;
  logic            ack;
  logic            owner_req;
  logic            other_req;
  logic            owner_id;
  state_t          other_state;
  logic [WIDTH-1:0] mux_out;

  eight_bit_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .control(sel),
    .in1    (data0),
    .in2    (data1),
    .out    (mux_out)
  );

  // State register together with the beat counter and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= 1'b0;
      count       <= '0;
      last_served <= 1'b1;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_next;
      sel         <= sel_next;
      count       <= count_next;
      last_served <= last_served_next;
      if (ack) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign owner_id    = (state == OWN1);
  assign owner_req   = owner_id ? req1 : req0;
  assign other_req   = owner_id ? req0 : req1;
  assign other_state = owner_id ? OWN0 : OWN1;

  always_comb begin
    state_next       = state;
    count_next       = count;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = last_served ? OWN0 : OWN1;
        end else if (req0) begin
          state_next = OWN0;
        end else if (req1) begin
          state_next = OWN1;
        end
      end
      OWN0, OWN1: begin
        // An owner dropping req, with or without a beat in flight, gives up the bus.
        if (!owner_req) begin
          state_next       = other_req ? other_state : IDLE;
          last_served_next = owner_id;
          count_next       = '0;
        end else if (ack) begin
          if (count == LAST_BEAT) begin
            count_next = '0;
            if (other_req) begin
              state_next       = other_state;
              last_served_next = owner_id;
            end
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // sel follows the owner on entry and holds its last value while idle.
    case (state_next)
      OWN0:    sel_next = 1'b0;
      OWN1:    sel_next = 1'b1;
      default: sel_next = sel;
    endcase
  end

  always_comb begin
    space = !out_valid || out_ready;
    ack0  = (state == OWN0) && req0 && space;
    ack1  = (state == OWN1) && req1 && space;
    ack   = ack0 || ack1;
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (WIDTH=8, MAX_BEATS=4).
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int total;
  int bad;

  bus_arbiter #(
    .WIDTH    (8),
    .MAX_BEATS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .data0    (data0),
    .ack0     (ack0),
    .req1     (req1),
    .data1    (data1),
    .ack1     (ack1),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    data0     = 8'h00;
    data1     = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({sel, out_valid, busy, ack0, ack1} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got sel/valid/busy/ack0/ack1=%b expected 00000",
               {sel, out_valid, busy, ack0, ack1});
    end
    total++;
    if (out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h expected 00", out_data);
    end
    $display("test_reset: sel=%b valid=%b busy=%b data=%h", sel, out_valid, busy, out_data);
  endtask

  task automatic test_single();
    do_reset();
    req0  = 1'b1;
    data0 = 8'hA5;
    #1;
    total++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got ack0=%b busy=%b expected 0 0", ack0, busy);
    end
    step();
    total++;
    if (ack0 !== 1'b1 || sel !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: got ack0=%b sel=%b busy=%b expected 1 0 1", ack0, sel, busy);
    end
    step();
    req0 = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_data: got valid=%b data=%h expected 1 a5", out_valid, out_data);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_release: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    $display("test_single: beat a5 delivered");
  endtask

  task automatic test_alternate();
    logic       owner;
    logic [7:0] exp_byte;
    do_reset();
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'hA0;
    data1 = 8'hB0;
    step();
    for (int i = 0; i < 12; i++) begin
      owner = ((i / 4) % 2) == 1;
      total++;
      if (ack0 !== !owner || ack1 !== owner || sel !== owner) begin
        bad++;
        $display("FAIL alt_ack[%0d]: got ack0=%b ack1=%b sel=%b expected %b %b %b",
                 i, ack0, ack1, sel, !owner, owner, owner);
      end
      exp_byte = owner ? data1 : data0;
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte) begin
        bad++;
        $display("FAIL alt_data[%0d]: got valid=%b data=%h expected 1 %h",
                 i, out_valid, out_data, exp_byte);
      end
      if (owner) data1 = data1 + 8'h01;
      else       data0 = data0 + 8'h01;
      $display("test_alternate beat %0d: owner=%0d data=%h", i, owner, out_data);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_stream1();
    do_reset();
    req1  = 1'b1;
    data1 = 8'h10;
    step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (ack1 !== 1'b1 || ack0 !== 1'b0 || sel !== 1'b1) begin
        bad++;
        $display("FAIL stream_ack[%0d]: got ack1=%b ack0=%b sel=%b expected 1 0 1",
                 i, ack1, ack0, sel);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i)) begin
        bad++;
        $display("FAIL stream_data[%0d]: got valid=%b data=%h expected 1 %h",
                 i, out_valid, out_data, 8'h10 + 8'(i));
      end
      data1 = data1 + 8'h01;
      $display("test_stream1 beat %0d: data=%h", i, out_data);
    end
    req1 = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0  = 1'b1;
    data0 = 8'h3C;
    step();
    step();
    data0     = 8'h3D;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ack0 !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h3C) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got ack0=%b valid=%b data=%h expected 0 1 3c",
                 k, ack0, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (ack0 !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume_ack: got %b expected 1", ack0);
    end
    step();
    total++;
    if (out_data !== 8'h3D) begin
      bad++;
      $display("FAIL bp_resume_data0: got %h expected 3d", out_data);
    end
    data0 = 8'h3E;
    #1;
    total++;
    if (ack0 !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume_ack2: got %b expected 1", ack0);
    end
    step();
    total++;
    if (out_data !== 8'h3E || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume_data1: got valid=%b data=%h expected 1 3e", out_valid, out_data);
    end
    req0 = 1'b0;
    $display("test_backpressure: held 3c, resumed with 3d 3e");
  endtask

  task automatic test_drop();
    do_reset();
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h50;
    data1 = 8'h60;
    step();
    step();
    data0 = 8'h51;
    step();
    total++;
    if (out_data !== 8'h51) begin
      bad++;
      $display("FAIL drop_beat2: got %h expected 51", out_data);
    end
    req0 = 1'b0;
    #1;
    total++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      bad++;
      $display("FAIL drop_noack: got ack0=%b ack1=%b expected 0 0", ack0, ack1);
    end
    step();
    total++;
    if (sel !== 1'b1 || ack1 !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_handoff: got sel=%b ack1=%b valid=%b expected 1 1 0",
               sel, ack1, out_valid);
    end
    step();
    total++;
    if (out_data !== 8'h60 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_data1: got valid=%b data=%h expected 1 60", out_valid, out_data);
    end
    req1 = 1'b0;
    $display("test_drop: handed to requester 1, data=%h", out_data);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h70;
    data1 = 8'h80;
    repeat (5) step();
    total++;
    if (sel !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_before: got sel=%b valid=%b busy=%b expected 1 1 1",
               sel, out_valid, busy);
    end
    reset = 1'b1;
    #2;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sel !== 1'b0 || ack1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b busy=%b sel=%b ack1=%b expected 0 0 0 0",
               out_valid, busy, sel, ack1);
    end
    reset = 1'b0;
    step();
    total++;
    if (sel !== 1'b0 || ack0 !== 1'b1 || ack1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_tie: got sel=%b ack0=%b ack1=%b expected 0 1 0", sel, ack0, ack1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    $display("test_reset_mid: tie after reset went to requester %0d", sel);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    data0     = 8'h00;
    data1     = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_stream1();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
